// File: rtl/video_pattern_pkg.sv
// Shared colours, mode encodings and palette lookup for the video test-pattern generator.
package video_pattern_pkg;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;

  typedef enum logic [2:0] {
    PAL_WHITE   = 3'd0,
    PAL_BLACK   = 3'd1,
    PAL_RED     = 3'd2,
    PAL_GREEN   = 3'd3,
    PAL_BLUE    = 3'd4,
    PAL_CYAN    = 3'd5,
    PAL_MAGENTA = 3'd6,
    PAL_YELLOW  = 3'd7
  } pal_e;

  localparam logic [2:0] MODE_BARS  = 3'd0;
  localparam logic [2:0] MODE_RAMP  = 3'd1;
  localparam logic [2:0] MODE_CHECK = 3'd2;
  localparam logic [2:0] MODE_BOX   = 3'd3;

  function automatic logic [23:0] paletteRgb(input logic [2:0] idx);
    logic [23:0] rgb;
    rgb = RGB_BLACK;
    case (idx)
      PAL_WHITE:   rgb = RGB_WHITE;
      PAL_BLACK:   rgb = RGB_BLACK;
      PAL_RED:     rgb = RGB_RED;
      PAL_GREEN:   rgb = RGB_GREEN;
      PAL_BLUE:    rgb = RGB_BLUE;
      PAL_CYAN:    rgb = RGB_CYAN;
      PAL_MAGENTA: rgb = RGB_MAGENTA;
      PAL_YELLOW:  rgb = RGB_YELLOW;
      default:     rgb = RGB_BLACK;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/video_pattern_gen_box_mover.sv
// Bouncing-box position tracker; advances one step per frame-end strobe on both axes.
module video_box_mover #(
  parameter int H_DISP   = 1280,
  parameter int V_DISP   = 720,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frameEnd_i,
  output logic [10:0] boxX_o,
  output logic [10:0] boxY_o
);

  logic [10:0] boxX_q, boxX_d, boxY_q, boxY_d;
  logic        dirRight_q, dirRight_d, dirDown_q, dirDown_d;

  // Returns {forward, position}; forward means right (X) or down (Y).
  function automatic logic [11:0] nextAxis(input logic [10:0] pos, input logic fwd,
                                           input int limit);
    logic [10:0] p;
    logic        f;
    p = pos;
    f = fwd;
    if (fwd) begin
      if (int'(pos) + BOX_SIZE + BOX_STEP > limit) begin
        p = 11'(limit - BOX_SIZE);
        f = 1'b0;
      end else begin
        p = pos + 11'(BOX_STEP);
      end
    end else begin
      if (int'(pos) < BOX_STEP) begin
        p = '0;
        f = 1'b1;
      end else begin
        p = pos - 11'(BOX_STEP);
      end
    end
    return {f, p};
  endfunction

  always_comb begin
    {dirRight_d, boxX_d} = {dirRight_q, boxX_q};
    {dirDown_d, boxY_d}  = {dirDown_q, boxY_q};
    if (frameEnd_i) begin
      {dirRight_d, boxX_d} = nextAxis(boxX_q, dirRight_q, H_DISP);
      {dirDown_d, boxY_d}  = nextAxis(boxY_q, dirDown_q, V_DISP);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      boxX_q     <= '0;
      boxY_q     <= '0;
      dirRight_q <= 1'b1;
      dirDown_q  <= 1'b1;
    end else begin
      boxX_q     <= boxX_d;
      boxY_q     <= boxY_d;
      dirRight_q <= dirRight_d;
      dirDown_q  <= dirDown_d;
    end
  end

  assign boxX_o = boxX_q;
  assign boxY_o = boxY_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Multi-mode test-pattern generator (bars, grey ramp, checker, bouncing box, solid fills).
// Optional white one-pixel frame border enabled by defining VIDEO_PATTERN_BORDER_EN.
module video_pattern_gen
  import video_pattern_pkg::*;
#(
  parameter int H_DISP     = 1280,
  parameter int V_DISP     = 720,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  parameter int BOX_STEP   = 4
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [2:0]  mode_sel,
  output logic [23:0] pixel_data,
  output logic [2:0]  active_mode,
  output logic [7:0]  frame_cnt
);

  logic [23:0] colour_q, colour_d, pixelData_q;
  logic [2:0]  activeMode_q, modeEff, barIdx;
  logic [7:0]  frameCnt_q, grey;
  logic [10:0] boxX, boxY;
  logic        frameStart, frameEnd, inActive, checkBit, boxHit;

  // Exact floor(x*256/H_DISP); divisor is a constant so this folds to fixed logic.
  function automatic logic [7:0] rampLevel(input logic [10:0] x);
    return 8'(({21'd0, x} << 8) / 32'(H_DISP));
  endfunction

  assign frameStart = (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
  assign frameEnd   = (pixel_xpos == 11'(H_DISP - 1)) && (pixel_ypos == 11'(V_DISP - 1));
  assign inActive   = (int'(pixel_xpos) < H_DISP) && (int'(pixel_ypos) < V_DISP);
  assign modeEff    = frameStart ? mode_sel : activeMode_q;
  assign grey       = rampLevel(pixel_xpos);
  assign checkBit   = pixel_xpos[CHECK_LOG2] ^ pixel_ypos[CHECK_LOG2];
  assign boxHit     = (int'(pixel_xpos) >= int'(boxX)) && (int'(pixel_xpos) < int'(boxX) + BOX_SIZE) &&
                      (int'(pixel_ypos) >= int'(boxY)) && (int'(pixel_ypos) < int'(boxY) + BOX_SIZE);

  // Highest bar whose left edge is at or before x; the last bar absorbs the rounding slack.
  always_comb begin
    barIdx = '0;
    for (int i = 1; i < NUM_BARS; i++) begin
      if (int'(pixel_xpos) >= (i * H_DISP) / NUM_BARS) barIdx = 3'(i);
    end
  end

`ifdef VIDEO_PATTERN_BORDER_EN
  logic onBorder;
  assign onBorder = (pixel_xpos == 11'd0) || (pixel_xpos == 11'(H_DISP - 1)) ||
                    (pixel_ypos == 11'd0) || (pixel_ypos == 11'(V_DISP - 1));
`endif

  always_comb begin
    colour_d = RGB_BLACK;
    if (inActive) begin
      case (modeEff)
        MODE_BARS:  colour_d = paletteRgb(barIdx);
        MODE_RAMP:  colour_d = {grey, grey, grey};
        MODE_CHECK: colour_d = checkBit ? RGB_WHITE : RGB_BLACK;
        MODE_BOX:   colour_d = boxHit ? RGB_WHITE : RGB_BLUE;
        default:    colour_d = paletteRgb(modeEff);
      endcase
`ifdef VIDEO_PATTERN_BORDER_EN
      if (onBorder) colour_d = RGB_WHITE;
`endif
    end
  end

  // Two-stage pipeline: pattern register, then output register.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      colour_q     <= RGB_BLACK;
      pixelData_q  <= RGB_BLACK;
      activeMode_q <= '0;
      frameCnt_q   <= '0;
    end else begin
      colour_q    <= colour_d;
      pixelData_q <= colour_q;
      if (frameStart) activeMode_q <= mode_sel;
      if (frameEnd) frameCnt_q <= frameCnt_q + 8'd1;
    end
  end

  video_box_mover #(
    .H_DISP  (H_DISP),
    .V_DISP  (V_DISP),
    .BOX_SIZE(BOX_SIZE),
    .BOX_STEP(BOX_STEP)
  ) u_box_mover (
    .clk_i     (pixel_clk),
    .rst_i     (sys_rst),
    .frameEnd_i(frameEnd),
    .boxX_o    (boxX),
    .boxY_o    (boxY)
  );

  assign pixel_data  = pixelData_q;
  assign active_mode = activeMode_q;
  assign frame_cnt   = frameCnt_q;

endmodule
